fact_arb_seq: RTL and testbench
===============================

# fact_arb_seq

- Multi-cycle, shared evaluator for R = (n · n!) / (2n + 1), with bit-exact 32-bit truncation semantics.
- Two requesters share one iterative multiply step and one restoring divider.
- A round-robin arbiter picks which requester is served.
- Sits between the experiment's control logic and the result display, replacing the single-cycle combinational evaluator.

## Interface
Parameters:
- none (widths fixed: n 4 bits, datapath 32 bits)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- req0  in  1  requester 0 request; level, held until ack0
- n0  in  4  requester 0 operand; stable while req0 high
- req1  in  1  requester 1 request; level, held until ack1
- n1  in  4  requester 1 operand; stable while req1 high
- ack0  out  1  one-cycle pulse: requester 0 accepted, n0 captured
- ack1  out  1  one-cycle pulse: requester 1 accepted, n1 captured
- busy  out  1  high from accept through the result cycle
- result  out  32  last computed value; held until the next result
- res_valid  out  1  one-cycle pulse when result updates
- res_id  out  1  requester owning result; held with result

## Operation
- Arithmetic:
  - F = n! mod 2^32, with F(0) = 0 and F(1) = 1.
  - P = (n · F) mod 2^32.
  - R = floor(P / (2n + 1)). The divisor is in 1..31 and is never 0.
- Arbitration, evaluated only in IDLE:
  - Exactly one req high: grant that requester.
  - Both high: grant the one not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
- State machine: IDLE, FACT, MUL, DIV, DONE.
  - IDLE → accept:
    - Latch n and the owner id.
    - Pulse ack for the owner.
    - Set acc = (n != 0), idx = 2.
    - Next state: FACT if n ≥ 2, else MUL.
  - FACT: acc ← (acc · idx) mod 2^32, idx ← idx + 1. Leave to MUL in the cycle where idx == n. Lasts exactly n − 1 cycles.
  - MUL: P ← (n · acc) mod 2^32. Load the divider with P and divisor 2n + 1. 1 cycle.
  - DIV: restoring division, one quotient bit per cycle, MSB first. Exactly 32 cycles. On the last cycle, write result and res_id, and assert res_valid for the following cycle.
  - DONE: res_valid high; go to IDLE. No accept occurs in DONE.
- Requests arriving while busy wait; they are never dropped as long as req stays high.
- After ack, a requester must drop req within 1 cycle. A req still high in the next IDLE is treated as a new request.

## Timing
- Reset values:
  - state IDLE
  - ack0 = ack1 = 0
  - busy = 0
  - result = 0
  - res_valid = 0
  - res_id = 0
  - last_grant = 1
- Accept edge E0 occurs in the IDLE cycle with a granted req. ack and busy are high in the cycle after E0.
- res_valid is high in the cycle after edge E0 + max(n − 1, 0) + 33:
  - n ≥ 2: n + 33 cycles after the accept cycle.
  - n ≤ 1: 34 cycles after the accept cycle.
- busy drops on the edge that ends DONE. Earliest next accept is the edge after that, so there is 1 idle cycle between jobs.
- Back-to-back with both requesters pending: grants alternate 0, 1, 0, ….
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight job is lost with no res_valid.
  - After release, a pending req is re-arbitrated with requester 0 first on a tie.

## Test plan
- Reset, then req0 with n0 = 3 → ack0 one cycle after accept; res_valid 36 cycles after accept; result = 2, res_id = 0.
- req1 with n1 = 5 → result 54. Then n1 = 4 → result 10. Then n1 = 1 → result 0 at 34 cycles. Then n1 = 0 → result 0 at 34 cycles.
- Truncation: n = 12 → result 58122076. n = 15 → result 138543434 (P = 4294846464, divisor 31).
- req0 and req1 high on the same cycle after reset, n0 = 3, n1 = 5:
  - Job 1: ack0, result 2, id 0.
  - Job 2: ack1, result 54, id 1.
  - Third round with both high again grants req0.
- Pull reset low during DIV of an n = 15 job:
  - Outputs go to reset values asynchronously, before the next clk edge.
  - No res_valid.
  - After release, a held req1 with n1 = 5 completes with result 54.
- result and res_id hold their value across idle cycles and during the next job, until the next res_valid.

Source files
------------

// File: rtl/fact_arb_seq.sv
// fact_arb_seq
//   Shared multi-cycle evaluator for R = (n * n!) / (2n + 1), with every
//   intermediate truncated to 32 bits. Two requesters share one iterative
//   multiply step and one restoring divider. A round-robin arbiter, which is
//   evaluated only while idle, decides which requester is served.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset; all state cleared while low
//   req0/n0    requester 0 level request and 4-bit operand
//   req1/n1    requester 1 level request and 4-bit operand
//   ack0/ack1  one-cycle pulse in the cycle after a request is accepted
//   busy       high from the cycle after accept through the result cycle
//   result     last computed value, held until the next result
//   res_valid  one-cycle pulse in the cycle that result is updated
//   res_id     requester that owns result, held with result
module fact_arb_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [3:0]  n0,
  input  logic        req1,
  input  logic [3:0]  n1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic [31:0] result,
  output logic        res_valid,
  output logic        res_id
);

  typedef enum logic [2:0] {IDLE, FACT, MUL, DIV, DONE} state_t;

  state_t      state_reg, state_next;

  logic [3:0]  n_reg;          // latched operand of the job in flight
  logic        id_reg;         // owner of the job in flight
  logic        last_grant_reg;
  logic [31:0] acc_reg;        // running factorial
  logic [3:0]  idx_reg;        // next factor to multiply in
  logic [31:0] quo_reg;        // dividend shifting out, quotient shifting in
  logic [4:0]  rem_reg;        // partial remainder, always below divisor
  logic [4:0]  div_reg;        // divisor 2n + 1
  logic [4:0]  cnt_reg;        // quotient bit counter
  logic        ack0_reg, ack1_reg;
  logic [31:0] result_reg;
  logic        res_id_reg;

  // Arbitration
  logic        grant_valid;
  logic        grant_id;
  logic [3:0]  n_sel;

  // Restoring divider step
  logic [5:0]  div_trial;
  logic        div_ge;
  logic [5:0]  div_diff;
  logic        q_bit;

  always_comb begin
    grant_valid = req0 | req1;
    // On a tie the requester that was not served last wins.
    grant_id    = (req0 && req1) ? ~last_grant_reg : req1;
    n_sel       = grant_id ? n1 : n0;
  end

  always_comb begin
    div_trial = {rem_reg, quo_reg[31]};
    div_ge    = (div_trial >= {1'b0, div_reg});
    div_diff  = div_trial - {1'b0, div_reg};
    q_bit     = div_ge;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    res_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = (n_sel >= 4'd2) ? FACT : MUL;
        end
      end
      FACT: begin
        busy = 1'b1;
        // Last factor is multiplied in this cycle.
        if (idx_reg == n_reg) begin
          state_next = MUL;
        end
      end
      MUL: begin
        busy       = 1'b1;
        state_next = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt_reg == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        res_valid  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg          <= 4'd0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      acc_reg        <= 32'd0;
      idx_reg        <= 4'd0;
      quo_reg        <= 32'd0;
      rem_reg        <= 5'd0;
      div_reg        <= 5'd0;
      cnt_reg        <= 5'd0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      result_reg     <= 32'd0;
      res_id_reg     <= 1'b0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            n_reg          <= n_sel;
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            ack0_reg       <= ~grant_id;
            ack1_reg       <= grant_id;
            // 0! is defined as 0 here, so acc starts at 0 for n = 0.
            acc_reg        <= {31'd0, (n_sel != 4'd0)};
            idx_reg        <= 4'd2;
          end
        end
        FACT: begin
          acc_reg <= acc_reg * {28'd0, idx_reg};
          idx_reg <= idx_reg + 4'd1;
        end
        MUL: begin
          quo_reg <= acc_reg * {28'd0, n_reg};
          rem_reg <= 5'd0;
          div_reg <= {n_reg, 1'b1};
          cnt_reg <= 5'd0;
        end
        DIV: begin
          quo_reg <= {quo_reg[30:0], q_bit};
          rem_reg <= div_ge ? div_diff[4:0] : div_trial[4:0];
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            result_reg <= {quo_reg[30:0], q_bit};
            res_id_reg <= id_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ack0   = ack0_reg;
  assign ack1   = ack1_reg;
  assign result = result_reg;
  assign res_id = res_id_reg;

endmodule

// File: tb/tb_fact_arb_seq.sv
// tb_fact_arb_seq
//   Self-checking bench for fact_arb_seq. A job-level model (accept edge,
//   job length, arithmetic result) predicts every output on every cycle;
//   directed jobs additionally pin results and latencies to literal values.
module tb_fact_arb_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0;
  logic [3:0]  n0 = 4'd0;
  logic        req1 = 1'b0;
  logic [3:0]  n1 = 4'd0;
  logic        ack0, ack1, busy, res_valid, res_id;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  fact_arb_seq dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .n0        (n0),
    .req1      (req1),
    .n1        (n1),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy),
    .result    (result),
    .res_valid (res_valid),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- job-level model ----------------
  function automatic logic [31:0] model_r(input int n);
    longint unsigned f;
    longint unsigned p;
    f = (n == 0) ? 0 : 1;
    for (int i = 2; i <= n; i++) f = (f * longint'(i)) & 64'hFFFF_FFFF;
    p = (longint'(n) * f) & 64'hFFFF_FFFF;
    return 32'(p / longint'(2 * n + 1));
  endfunction

  int          e = 0;        // edge counter; cycle after edge k is cycle k
  bit          m_job = 0;
  int          m_E = 0;      // edge at which the current job was accepted
  int          m_d = 0;      // busy cycles of the current job
  int          m_n = 0;
  bit          m_gid = 0;
  bit          m_last = 1;
  logic [31:0] m_r = 0;
  logic [31:0] m_result = 0;
  bit          m_id = 0;

  always @(posedge clk) begin
    bit g;
    e = e + 1;
    if (!reset) begin
      m_job    = 0;
      m_last   = 1;
      m_result = 0;
      m_id     = 0;
    end else begin
      if ((!m_job || e >= m_E + m_d + 1) && (req0 || req1)) begin
        g      = (req0 && req1) ? !m_last : req1;
        m_job  = 1;
        m_E    = e;
        m_gid  = g;
        m_n    = g ? int'(n1) : int'(n0);
        m_d    = ((m_n >= 2) ? m_n - 1 : 0) + 34;
        m_r    = model_r(m_n);
        m_last = g;
      end
      if (m_job && e == m_E + m_d - 1) begin
        m_result = m_r;
        m_id     = m_gid;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, e);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic x_ack0, x_ack1, x_busy, x_rv, x_id;
    logic [31:0] x_res;
    if (!reset) begin
      x_ack0 = 0; x_ack1 = 0; x_busy = 0; x_rv = 0; x_res = 0; x_id = 0;
    end else begin
      x_ack0 = m_job && e == m_E && !m_gid;
      x_ack1 = m_job && e == m_E && m_gid;
      x_busy = m_job && e >= m_E && e <= m_E + m_d - 1;
      x_rv   = m_job && e == m_E + m_d - 1;
      x_res  = m_result;
      x_id   = m_id;
    end
    check("ack0", 32'(ack0), 32'(x_ack0));
    check("ack1", 32'(ack1), 32'(x_ack1));
    check("busy", 32'(busy), 32'(x_busy));
    check("res_valid", 32'(res_valid), 32'(x_rv));
    check("result", result, x_res);
    check("res_id", 32'(res_id), 32'(x_id));
  end

  // ---------------- stimulus helpers ----------------
  task automatic serve(input int id, input logic [3:0] n, output int ack_cyc);
    bit got;
    got = 0;
    ack_cyc = 0;
    @(negedge clk);
    if (id == 0) begin req0 = 1'b1; n0 = n; end
    else         begin req1 = 1'b1; n1 = n; end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        got = 1;
        ack_cyc = e;
      end
    end
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack, required one", id);
    end
  endtask

  task automatic wait_result(input int id, input int n, input logic [31:0] exp_r,
                             input int ack_cyc, input int exp_lat);
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1;
        $display("job id=%0d n=%0d result=%0d res_id=%0d latency=%0d", id, n, result, res_id,
                 e - ack_cyc + 1);
        check("job_result", result, exp_r);
        check("job_res_id", 32'(res_id), 32'(id));
        check("job_latency", 32'(e - ack_cyc + 1), 32'(exp_lat));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: requester %0d got no res_valid, required one", id);
    end
  endtask

  task automatic run_job(input int id, input int n, input logic [31:0] exp_r, input int exp_lat);
    int a;
    serve(id, 4'(n), a);
    wait_result(id, n, exp_r, a, exp_lat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, a1, ar;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_res_valid", 32'(res_valid), 32'd0);

    // Single jobs; latency counted from the accept cycle.
    run_job(0, 3, 32'd2, 36);
    run_job(1, 5, 32'd54, 38);
    serve(1, 4'd4, a1);
    check("hold_result", result, 32'd54);
    check("hold_res_id", 32'(res_id), 32'd1);
    wait_result(1, 4, 32'd10, a1, 37);
    run_job(1, 1, 32'd0, 34);
    run_job(1, 0, 32'd0, 34);
    run_job(0, 12, 32'd58122076, 45);
    run_job(1, 15, 32'd138543434, 48);

    // Tie after a requester-1 job: requester 0 first, then alternation.
    repeat (2) begin
      fork
        begin serve(0, 4'd3, a0); wait_result(0, 3, 32'd2, a0, 36); end
        begin serve(1, 4'd5, a1); wait_result(1, 5, 32'd54, a1, 38); end
      join
      check("tie_order", 32'(a0 < a1), 32'd1);
    end

    // Reset in the middle of DIV of an n = 15 job with req1 waiting.
    serve(0, 4'd15, a0);
    fork
      begin serve(1, 4'd5, ar); wait_result(1, 5, 32'd54, ar, 38); end
    join_none
    repeat (20) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_result", result, 32'd0);
    check("async_res_id", 32'(res_id), 32'd0);
    check("async_res_valid", 32'(res_valid), 32'd0);
    check("async_ack1", 32'(ack1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait fork;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
